// File: rtl/spi_bus_arb.sv
// spi_bus_arb: shares one SPI_mnrch master between two clients.
// Client 0 is the inert_intf command stream. Client 1 is the A2D/battery or IR reader.
// The winner's 16-bit command is latched, and a single-cycle wrt is issued.
// The arbiter then waits for the SPI done, returns rd_data and a done pulse to the owner,
// and steers the shared SS_n to the owner's device select.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a BUSY that lasts
// TIMEOUT_CYC cycles without spi_done (err pulse instead of done).
//
// Handshake: a client raises req[i] with cmd<i> stable and holds both until it
// sees done[i] (or err[i]) for one cycle; it may drop req in that same cycle.
// spi_wrt is a one-cycle strobe; spi_cmd is valid while it is high and stays
// stable until the next grant.
module spi_bus_arb #(
  parameter int TIMEOUT_CYC = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [15:0] rd_data,
  output logic [1:0]  err,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  input  logic        spi_ss_n,
  output logic [1:0]  ss_n,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] BUSY    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("spi_bus_arb: TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]  state;
  logic [1:0]  own;       // one-hot owner, kept after RELEASE for ss_n routing
  logic        rr_ptr;    // client favoured when both request
  logic [15:0] cmd_q;
  logic        win;       // index of the client that wins in IDLE
  logic        owner_idx;

  assign owner_idx = own[1];

  // Pick the winner: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)      win = 1'b1;
    else if (req == 2'b11) win = rr_ptr;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt;
  logic [1:0]    err_q;
  logic          timeout_hit;

  // Fires on the TIMEOUT_CYC-th BUSY cycle; spi_done in that cycle takes priority.
  assign timeout_hit = (state == BUSY) && !spi_done && (to_cnt == CW'(TIMEOUT_CYC - 1));

  // Count BUSY cycles; cleared in ISSUE so every transaction starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state == ISSUE) to_cnt <= '0;
    else if (state == BUSY)  to_cnt <= to_cnt + CW'(1);
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

  // Main sequencer: grant, strobe wrt, wait for SPI completion, release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      own     <= 2'b00;
      rr_ptr  <= 1'b0;
      cmd_q   <= 16'h0000;
      spi_wrt <= 1'b0;
      done    <= 2'b00;
      rd_data <= 16'h0000;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q   <= 2'b00;
`endif
    end else begin
      spi_wrt <= 1'b0;
      done    <= 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q   <= 2'b00;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            own   <= win ? 2'b10 : 2'b01;
            cmd_q <= win ? cmd1 : cmd0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          spi_wrt <= 1'b1;
          state   <= BUSY;
        end
        BUSY: begin
          if (spi_done) begin
            rd_data <= spi_rd_data;
            done    <= own;
            rr_ptr  <= ~owner_idx;
            state   <= RELEASE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q  <= own;
            rr_ptr <= ~owner_idx;
            state  <= RELEASE;
          end
`endif
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt       = (state == IDLE) ? 2'b00 : own;
  assign spi_cmd   = cmd_q;
  assign ss_n      = {2{spi_ss_n}} | ~own;
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: self-checking bench for spi_bus_arb with a behavioural SPI
// slave. Define SPI_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_spi_bus_arb;

  localparam int TO_CYC = 16;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] cmd0, cmd1;
  logic [1:0]  gnt, done, err, ss_n, state_dbg;
  logic [15:0] rd_data, spi_cmd, spi_rd_data;
  logic        spi_wrt, spi_done, spi_ss_n;

  spi_bus_arb #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .gnt(gnt), .done(done), .rd_data(rd_data), .err(err),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done),
    .spi_rd_data(spi_rd_data), .spi_ss_n(spi_ss_n), .ss_n(ss_n),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_cmd_q[$];
  logic [1:0]  exp_gnt_q[$];
  logic [17:0] exp_done_q[$];   // {one-hot owner, rd_data}

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wrt_cnt  = 0;
  int          done_cnt = 0;
  int          poke_cnt = 0;
  logic [1:0]  cur_owner = 2'b00;
  logic [15:0] last_rd   = 16'h0000;
  bit          spi_hang  = 1'b0;
  bit          fixed_rd_en = 1'b0;
  logic [15:0] fixed_rd  = 16'h0000;
  bit          to_test   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  // ---------------- SPI slave model ----------------
  initial begin : spi_model
    int          xfer;
    int          poke_seen;
    bit          was_hung;
    logic [15:0] rd;
    poke_seen   = 0;
    spi_done    = 1'b0;
    spi_ss_n    = 1'b1;
    spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (spi_wrt && rst_n) begin
        spi_ss_n = 1'b0;
        was_hung = spi_hang;
        xfer = $urandom_range(1, 5);
        repeat (xfer) @(negedge clk);
        while (spi_hang) @(negedge clk);
        if (!was_hung) begin
          rd = fixed_rd_en ? fixed_rd : 16'($urandom);
          spi_rd_data = rd;
          spi_done = 1'b1;
          exp_done_q.push_back({cur_owner, rd});
          @(negedge clk);
          spi_done = 1'b0;
        end
        spi_ss_n = 1'b1;
      end else if (poke_cnt != poke_seen) begin
        poke_seen++;
        spi_rd_data = 16'hDEAD;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [15:0] m_cmd;
  logic [1:0]  m_gnt;
  logic [17:0] m_done;

  // Pops the expected queues whenever the DUT strobes wrt or pulses done.
  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      last_rd = 16'h0000;
    end else begin
      if (spi_wrt) begin
        wrt_cnt++;
        if (exp_cmd_q.size() == 0) check("wrt_unexpected", 32'(spi_wrt), 32'h0);
        else begin
          m_cmd = exp_cmd_q.pop_front();
          m_gnt = exp_gnt_q.pop_front();
          cur_owner = m_gnt;
          check("spi_cmd_at_wrt", 32'(spi_cmd), 32'(m_cmd));
          check("gnt_at_wrt", 32'(gnt), 32'(m_gnt));
        end
      end
      if (done != 2'b00) begin
        done_cnt++;
        if (exp_done_q.size() == 0) check("done_unexpected", 32'(done), 32'h0);
        else begin
          m_done = exp_done_q.pop_front();
          check("done_owner", 32'(done), 32'(m_done[17:16]));
          check("rd_data", 32'(rd_data), 32'(m_done[15:0]));
          last_rd = m_done[15:0];
        end
      end
      if (!to_test && err != 2'b00) check("err_idle", 32'(err), 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_txn(input logic [15:0] c, input logic [1:0] g);
    exp_cmd_q.push_back(c);
    exp_gnt_q.push_back(g);
  endtask

  task automatic wait_wrt(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (spi_wrt) hit = 1'b1;
    end
    if (!hit) check("wrt_timeout", 32'(spi_wrt), 32'h1);
  endtask

  task automatic wait_done(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (done != 2'b00) hit = 1'b1;
    end
    if (!hit) check("done_timeout", 32'(done), 32'h1);
  endtask

  task automatic wait_err(input logic [1:0] which);
    wait_wrt(20);
    repeat (TO_CYC - 1) @(negedge clk);
    check("err_before_timeout", 32'(err), 32'h0);
    @(negedge clk);
    check("err_pulse", 32'(err), 32'(which));
    check("done_on_timeout", 32'(done), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    cmd0  = 16'h0000;
    cmd1  = 16'h0000;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_spi_wrt", 32'(spi_wrt), 32'h0);
    check("rst_spi_cmd", 32'(spi_cmd), 32'h0);
    check("rst_ss_n", 32'(ss_n), 32'h3);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single client 0 transaction: latency, ss_n routing, read data.
    fixed_rd_en = 1'b1;
    fixed_rd    = 16'h00A5;
    cmd0 = 16'h0D02;
    expect_txn(16'h0D02, 2'b01);
    req = 2'b01;
    @(negedge clk);
    check("wrt_lat_1clk", 32'(spi_wrt), 32'h0);
    @(negedge clk);
    check("wrt_lat_2clk", 32'(spi_wrt), 32'h1);
    check("spi_cmd_0d02", 32'(spi_cmd), 32'h0D02);
    @(negedge clk);
    check("ss_n_owner0", 32'(ss_n), 32'h2);
    wait_done(40);
    check("done_c0", 32'(done), 32'h1);
    check("rd_00a5", 32'(rd_data), 32'h00A5);
    req = 2'b00;
    fixed_rd_en = 1'b0;
    repeat (8) @(negedge clk);
    check("drop_req_one_wrt", 32'(wrt_cnt), 32'h1);
    check("ss_n_idle", 32'(ss_n), 32'h3);
    check("gnt_idle", 32'(gnt), 32'h0);

    // Client 0 keeps req after done: exactly one more transaction.
    base = wrt_cnt;
    cmd0 = 16'h1111;
    expect_txn(16'h1111, 2'b01);
    req = 2'b01;
    wait_done(40);
    cmd0 = 16'h2222;
    expect_txn(16'h2222, 2'b01);
    wait_done(40);
    req = 2'b00;
    repeat (8) @(negedge clk);
    check("keep_req_two_wrt", 32'(wrt_cnt - base), 32'h2);

    // spi_done outside BUSY is ignored.
    poke_cnt++;
    repeat (4) @(negedge clk);
    check("stray_done_out", 32'(done), 32'h0);
    check("stray_rd_data", 32'(rd_data), 32'(last_rd));

    // Client 1 changes cmd1 mid-transfer: spi_cmd must hold the latched word.
    cmd1 = 16'h1234;
    expect_txn(16'h1234, 2'b10);
    req = 2'b10;
    wait_wrt(20);
    cmd1 = 16'h5678;
    @(negedge clk);
    check("cmd_hold_busy", 32'(spi_cmd), 32'h1234);
    wait_done(40);
    check("cmd_hold_release", 32'(spi_cmd), 32'h1234);
    check("done_c1", 32'(done), 32'h2);
    req = 2'b00;
    repeat (4) @(negedge clk);

    // Both clients requesting continuously: grants alternate 0,1,0,1.
    do_reset();
    base = wrt_cnt;
    cmd0 = {8'hA6, 8'($urandom_range(0, 255))};
    cmd1 = 16'h8000;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_txn(cmd0, 2'b01);
      else            expect_txn(cmd1, 2'b10);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) wait_done(40);
    req = 2'b00;
    repeat (8) @(negedge clk);
    check("alt_wrt_count", 32'(wrt_cnt - base), 32'h4);

    // Reset during BUSY: outputs clear asynchronously, no done follows.
    spi_hang = 1'b1;
    cmd0 = 16'h3C3C;
    expect_txn(16'h3C3C, 2'b01);
    req = 2'b01;
    wait_wrt(20);
    @(negedge clk);
    check("ss_n_busy", 32'(ss_n), 32'h2);
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ss_n", 32'(ss_n), 32'h3);
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_wrt", 32'(spi_wrt), 32'h0);
    req = 2'b00;
    spi_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt - base), 32'h0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Hung SPI: each owner gets err after TO_CYC BUSY cycles, the other client is next.
    to_test  = 1'b1;
    spi_hang = 1'b1;
    cmd0 = 16'h4444;
    cmd1 = 16'h5555;
    expect_txn(16'h4444, 2'b01);
    expect_txn(16'h5555, 2'b10);
    req = 2'b11;
    wait_err(2'b01);
    wait_err(2'b10);
    req = 2'b00;
    check("timeout_rd_data", 32'(rd_data), 32'(last_rd));
    spi_hang = 1'b0;
    repeat (10) @(negedge clk);
    to_test = 1'b0;
`endif

    check("exp_cmd_q_empty", 32'(exp_cmd_q.size()), 32'h0);
    check("exp_done_q_empty", 32'(exp_done_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_bus_arb.md
Name: spi_bus_arb

Overview:
- Arbiter/sequencer that shares one SPI_mnrch instance between two clients: port 0 (inert_intf command stream) and port 1 (A2D/battery or IR sensor reader).
- Latches the winning client's 16-bit command and issues a single-cycle wrt to SPI_mnrch.
- Waits for SPI done, then returns rd_data and a done pulse to the owning client.
- Steers the shared SS_n from SPI_mnrch to the owner's device select.

Parameters:
- TIMEOUT_CYC, 2047, cycles in BUSY before abort. Used only when SPI_ARB_TIMEOUT_EN is defined. Must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  2  per-client request level; client holds req and its cmd stable until its done pulse
- cmd0  in  16  client 0 command word
- cmd1  in  16  client 1 command word
- gnt  out  2  one-hot owner indication, high ISSUE through RELEASE
- done  out  2  one-cycle per-client completion pulse, registered
- rd_data  out  16  last completed transaction's read data, registered
- err  out  2  one-cycle per-client timeout pulse; tied 0 without macro
- spi_wrt  out  1  to SPI_mnrch wrt
- spi_cmd  out  16  to SPI_mnrch wt_data
- spi_done  in  1  from SPI_mnrch done
- spi_rd_data  in  16  from SPI_mnrch rd_data
- spi_ss_n  in  1  from SPI_mnrch SS_n
- ss_n  out  2  per-device select: ss_n[i] = spi_ss_n | ~own[i]

Behaviour:
- Reset values:
  - state=IDLE; own=2'b00; rr_ptr=0 (client 0 favoured).
  - gnt=0, done=0, err=0, rd_data=0.
  - spi_wrt=0, spi_cmd=0.
  - ss_n=2'b11, because no owner is set.
- Reset mid-transaction aborts immediately: no done pulse, own cleared, ss_n forced 2'b11.
- States:
  - IDLE, on any req bit set:
    - Select the winner, latch its cmd into cmd_q, set own one-hot, go ISSUE.
    - Only one requester: it wins.
    - Both requesting: client rr_ptr wins.
  - ISSUE: spi_wrt=1 for exactly one cycle, spi_cmd=cmd_q; go BUSY.
  - BUSY:
    - spi_cmd stays cmd_q.
    - On spi_done: rd_data<=spi_rd_data, done[owner]<=1, rr_ptr<=~owner, go RELEASE.
  - RELEASE:
    - done[owner] is high in this cycle only.
    - req is ignored in this state, so the client can drop req in response to done.
    - Go IDLE.
- Latency: req rise in IDLE to spi_wrt is 2 clocks. spi_done to done pulse is 1 clock. Minimum gap between successive wrt pulses is 4 clocks plus the SPI transfer time.
- own is held after RELEASE until the next grant. This keeps ss_n routing correct while spi_ss_n deasserts after done.
- gnt equals own while in ISSUE, BUSY and RELEASE, and is 0 in IDLE.
- A req that is still high when IDLE is re-entered is treated as a new transaction.
- A req deasserted before grant is dropped silently.
- spi_done seen outside BUSY is ignored.
- The cmd0/cmd1 inputs are not re-sampled after grant; only cmd_q drives spi_cmd.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC without spi_done: err[owner]<=1 for one cycle, no done pulse, rd_data unchanged, rr_ptr<=~owner, go RELEASE.
  - spi_done arriving in the same cycle as the timeout wins: normal completion, no err.
- When undefined: no counter logic; err is constant 2'b00, and BUSY waits indefinitely.

Test Plan:
- Reset, then req=2'b01 with cmd0=16'h0D02:
  - spi_wrt pulses 2 clocks later with spi_cmd=16'h0D02.
  - ss_n[0] follows spi_ss_n while ss_n[1] stays 1.
  - spi_done with spi_rd_data=16'h00A5 -> done=2'b01 next clock and rd_data=16'h00A5.
- req=2'b11 held continuously with cmd0=16'hA6xx and cmd1=16'h8000: grants alternate 0,1,0,1. Each spi_cmd matches the granted client, and no client wins twice consecutively.
- cmd1 changes from 16'h1234 to 16'h5678 during BUSY: spi_cmd stays 16'h1234 until RELEASE.
- Assert rst_n low while in BUSY with ss_n=2'b10: ss_n becomes 2'b11, gnt=0 and spi_wrt=0 asynchronously, and no done pulse follows.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYC=16 and spi_done never asserted: err[owner] pulses after 16 BUSY cycles, done stays 0, and the other pending requester is granted next.
- Client 0 drops req in the done cycle: no second spi_wrt for client 0. If client 0 instead keeps req high, exactly one new transaction starts after RELEASE.
